// File: rtl/fsk_demod_pkg.sv
// Shared constants and types for the 2FSK link. The modulator and the demodulator
// both import this package, so tone increments and decision levels stay in step.
package fsk_demod_pkg;

    localparam int AD_W      = 12;
    localparam int AD_MID    = 2048;
    localparam int DEAD      = 16;
    localparam int WIN_LEN   = 64;
    localparam int THRESH    = 40;
    localparam int HYST      = 2;
    localparam int MIN_XING  = 16;
    localparam int DEBOUNCE  = 4;

    localparam int INC_SPACE = 18432;
    localparam int INC_MARK  = 22528;

    localparam int CNT_W     = 7;
    localparam int DEB_W     = $clog2(DEBOUNCE);

    typedef logic signed [AD_W:0] sample_t;

    typedef enum logic {
        DEC_SPACE = 1'b0,
        DEC_MARK  = 1'b1
    } dec_state_t;

    // Offset-binary ADC code to a signed sample centred on AD_MID.
    function automatic sample_t to_signed(input logic [AD_W-1:0] code);
        return sample_t'({1'b0, code}) - sample_t'(AD_MID);
    endfunction

endpackage

// File: rtl/fsk_demod_xing_window.sv
// Schmitt sign detector, zero-crossing detect and a sliding-window crossing count.
// The count is kept incrementally: the newest crossing enters, the oldest drops out.
module fsk_demod_xing_window
    import fsk_demod_pkg::*;
#(
    parameter int DEAD_P    = DEAD,
    parameter int WIN_LEN_P = WIN_LEN
) (
    input  logic             clk_sample,
    input  logic             rst_n,
    input  sample_t          s,
    output logic [CNT_W-1:0] count
);

    localparam sample_t DEAD_S = sample_t'(DEAD_P);

    logic                 sign;
    logic                 sign_d;
    logic                 xing;
    logic [WIN_LEN_P-1:0] window;

    assign xing = sign ^ sign_d;

    always_ff @(posedge clk_sample) begin
        if (!rst_n) begin
            sign   <= 1'b0;
            sign_d <= 1'b0;
            window <= '0;
            count  <= '0;
        end else begin
            // Samples exactly on the dead-band edge hold the previous sign.
            if (s > DEAD_S) begin
                sign <= 1'b1;
            end else if (s < -DEAD_S) begin
                sign <= 1'b0;
            end
            sign_d <= sign;
            window <= {window[WIN_LEN_P-2:0], xing};
            count  <= count + CNT_W'(xing) - CNT_W'(window[WIN_LEN_P-1]);
        end
    end

endmodule

// File: rtl/fsk_demod.sv
// 2FSK receiver: zero-crossing density decides mark/space with hysteresis, then a
// debounce stage drives the UART-level data output, forced idle without carrier.
//
// state     | meaning
// DEC_SPACE | crossing density says space tone (bit 0)
// DEC_MARK  | crossing density says mark tone (bit 1), also the reset state
module fsk_demod
    import fsk_demod_pkg::*;
(
    input  logic             clk_sample,
    input  logic             rst_n,
    input  logic [AD_W-1:0]  ad_data,
    output logic             data_out,
    output logic             carrier_det,
    output logic [CNT_W-1:0] xing_cnt
);

    logic [AD_W-1:0]  ad_q;
    sample_t          s;
    dec_state_t       dec;
    dec_state_t       dec_next;
    logic [DEB_W-1:0] deb_cnt;
    logic             dec_bit;

    assign s       = to_signed(ad_q);
    assign dec_bit = (dec == DEC_MARK);

    fsk_demod_xing_window #(
        .DEAD_P    (DEAD),
        .WIN_LEN_P (WIN_LEN)
    ) u_xing_window (
        .clk_sample (clk_sample),
        .rst_n      (rst_n),
        .s          (s),
        .count      (xing_cnt)
    );

    always_comb begin
        dec_next = dec;
        if (xing_cnt >= CNT_W'(THRESH + HYST)) begin
            dec_next = DEC_MARK;
        end else if (xing_cnt <= CNT_W'(THRESH - HYST)) begin
            dec_next = DEC_SPACE;
        end
    end

    always_ff @(posedge clk_sample) begin
        if (!rst_n) begin
            ad_q        <= '0;
            dec         <= DEC_MARK;
            carrier_det <= 1'b0;
            deb_cnt     <= '0;
            data_out    <= 1'b1;
        end else begin
            ad_q        <= ad_data;
            dec         <= dec_next;
            carrier_det <= (xing_cnt >= CNT_W'(MIN_XING));
            // Without carrier the line idles high regardless of the decision.
            if (!carrier_det) begin
                data_out <= 1'b1;
                deb_cnt  <= '0;
            end else if (dec_bit != data_out) begin
                if (deb_cnt == DEB_W'(DEBOUNCE - 1)) begin
                    data_out <= dec_bit;
                    deb_cnt  <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fsk_demod.sv
// Directed bench for fsk_demod: reset, silence, tones, debounce timing, noise,
// and a UART byte replayed through a DDS modulator model with a mid-byte reset.
module tb_fsk_demod;

    logic        clk_sample = 1'b0;
    logic        rst_n      = 1'b0;
    logic [11:0] ad_data    = 12'd2048;
    logic        data_out;
    logic        carrier_det;
    logic [6:0]  xing_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] phase  = 16'd0;

    localparam real TWO_PI = 6.283185307179586;
    localparam int  MARK   = 22528;
    localparam int  SPACE  = 18432;

    fsk_demod dut (
        .clk_sample  (clk_sample),
        .rst_n       (rst_n),
        .ad_data     (ad_data),
        .data_out    (data_out),
        .carrier_det (carrier_det),
        .xing_cnt    (xing_cnt)
    );

    always #5 clk_sample = ~clk_sample;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_sample);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_range(input string tag, input int observed, input int lo, input int hi);
        checks++;
        assert (observed >= lo && observed <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
        end
    endtask

    function automatic logic [11:0] dds_sample(input logic [15:0] ph);
        real r;
        r = 1800.0 * $sin(TWO_PI * real'(ph) / 65536.0);
        return 12'(2048 + int'(r));
    endfunction

    task automatic tone(input int inc, input int n);
        for (int i = 0; i < n; i++) begin
            ad_data = dds_sample(phase);
            phase   = phase + 16'(inc);
            tick();
        end
    endtask

    task automatic reset_dut();
        rst_n   = 1'b0;
        ad_data = 12'd2048;
        repeat (5) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int       lat;
        bit       glitch_ok;
        logic [9:0] frame;
        logic [9:0] bits;

        // 1: reset
        reset_dut();
        check("rst_data_out", data_out, 1);
        check("rst_carrier", carrier_det, 0);
        check("rst_xing_cnt", xing_cnt, 0);

        // 2: mid-scale silence
        ad_data = 12'd2048;
        repeat (300) tick();
        check("silence_cnt", xing_cnt, 0);
        check("silence_carrier", carrier_det, 0);
        check("silence_data", data_out, 1);

        // Crossing every sample just outside the dead band: exact pipeline timing
        reset_dut();
        for (int i = 1; i <= 100; i++) begin
            ad_data = (i % 2 == 1) ? 12'(2048 + 17) : 12'(2048 - 17);
            tick();
            if (i == 10) check("ramp_cnt_e10", xing_cnt, 8);
            if (i == 18) begin
                check("ramp_cnt_e18", xing_cnt, 16);
                check("ramp_carrier_e18", carrier_det, 0);
            end
            if (i == 19) check("ramp_carrier_e19", carrier_det, 1);
            if (i == 22) check("deb_fall_e22", data_out, 1);
            if (i == 23) check("deb_fall_e23", data_out, 0);
            if (i == 48) check("deb_rise_e48", data_out, 0);
            if (i == 49) check("deb_rise_e49", data_out, 1);
        end
        check("ramp_cnt_full", xing_cnt, 64);

        // Exactly +/-DEAD holds the sign: no crossings, window drains
        for (int i = 0; i < 70; i++) begin
            ad_data = (i % 2 == 0) ? 12'(2048 + 16) : 12'(2048 - 16);
            tick();
        end
        check("dead_edge_cnt", xing_cnt, 0);
        check("dead_edge_carrier", carrier_det, 0);
        check("dead_edge_data", data_out, 1);

        // 3: mark tone
        reset_dut();
        phase = 16'd0;
        tone(MARK, 80);
        check_range("mark_cnt", xing_cnt, 43, 45);
        check("mark_carrier", carrier_det, 1);
        check("mark_data", data_out, 1);

        // 4: switch to space tone
        tone(SPACE, 10);
        check("space_early_data", data_out, 1);
        lat = 10;
        while (data_out !== 1'b0 && lat < 72) begin
            tone(SPACE, 1);
            lat++;
        end
        check("space_fall_data", data_out, 0);
        tone(SPACE, 80);
        check_range("space_cnt", xing_cnt, 35, 37);

        glitch_ok = 1'b1;
        tone(MARK, 2);
        for (int i = 0; i < 100; i++) begin
            tone(SPACE, 1);
            if (data_out !== 1'b0) glitch_ok = 1'b0;
        end
        check("glitch_no_change", glitch_ok, 1);

        // 5: small noise inside the dead band
        for (int i = 0; i < 300; i++) begin
            ad_data = 12'(2038 + $urandom_range(0, 20));
            tick();
        end
        check("noise_cnt", xing_cnt, 0);
        check("noise_carrier", carrier_det, 0);
        check("noise_data", data_out, 1);

        // 6: 0x55 at 8 samples/bit, reset mid-byte
        frame = {1'b1, 8'h55, 1'b0};
        tone(MARK, 200);
        for (int b = 0; b < 5; b++) tone(frame[b] ? MARK : SPACE, 8);
        rst_n = 1'b0;
        tone(frame[5] ? MARK : SPACE, 1);
        check("midrst_data", data_out, 1);
        check("midrst_carrier", carrier_det, 0);
        check("midrst_cnt", xing_cnt, 0);
        rst_n = 1'b1;

        // 8 samples/bit is far shorter than the 64-sample window, so the restart
        // decode replays the frame with a bit period longer than the window.
        tone(MARK, 200);
        check("restart_idle_data", data_out, 1);
        check("restart_idle_carrier", carrier_det, 1);
        bits = '0;
        for (int b = 0; b < 10; b++) begin
            tone(frame[b] ? MARK : SPACE, 120);
            bits[b] = data_out;
            tone(frame[b] ? MARK : SPACE, 40);
        end
        check("uart_start", bits[0], 0);
        check("uart_byte", bits[8:1], 8'h55);
        check("uart_stop", bits[9], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
